divider_unit: RTL and testbench
===============================

DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 32, operand and result width in bits; only 32 is supported.
REQ-002 iCLK  input  1  Single clock; all state SHALL update on its rising edge.
REQ-003 iRST_N  input  1  Asynchronous, active-low reset.
REQ-004 iStart  input  1  Start request, sampled on the rising edge of iCLK.
REQ-005 iControl  input  5  Operation code, sampled with iStart: OPDIV, OPDIVU, OPREM or OPREMU.
REQ-006 iA  input  32  Dividend, sampled with iStart.
REQ-007 iB  input  32  Divisor, sampled with iStart.
REQ-008 oBusy  output  1  High while an operation is in flight.
REQ-009 oDone  output  1  One-cycle pulse; oResult is valid in the same cycle.
REQ-010 oResult  output  32  Quotient or remainder, held stable until the next accepted start.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, CALC, SIGN and DONE.
REQ-012 IDLE SHALL accept iStart=1 only; it SHALL latch iControl, iA and iB and go to CALC.
REQ-013 iStart SHALL be ignored while oBusy=1, with no effect on the operation in flight.
REQ-014 CALC SHALL perform exactly 32 restoring shift-subtract iterations on operand magnitudes, one per cycle, counted by a 5-bit counter that wraps 31->0 on the exit to SIGN.
REQ-015 SIGN SHALL apply signs for OPDIV/OPREM: the quotient is negated when the operand signs differ, and the remainder takes the dividend sign; unsigned operations SHALL pass through.
REQ-016 DONE SHALL drive oDone=1 for one cycle, update oResult, then return to IDLE.
REQ-017 In DONE, iStart=1 SHALL be ignored; the earliest accepted start is in the following IDLE cycle.
REQ-018 oBusy SHALL be 1 in CALC, SIGN and DONE, and 0 in IDLE.
REQ-019 Normal latency SHALL be: oDone high in the 34th cycle after the edge that sampled iStart.
REQ-020 Divide by zero (iB=0): OPDIV/OPDIVU SHALL return 0xFFFFFFFF, and OPREM/OPREMU SHALL return iA.
REQ-021 Signed overflow (iA=0x80000000, iB=0xFFFFFFFF): OPDIV SHALL return 0x80000000 and OPREM SHALL return 0.
REQ-022 Any other iControl value SHALL produce oResult=ZERO via the fast path (IDLE->DONE, oDone in cycle 2), regardless of configuration.
REQ-023 Magnitude computation SHALL handle -2^31 correctly, with no 33-bit sign loss.

Reset
REQ-024 iRST_N=0 SHALL asynchronously force: state IDLE, oBusy=0, oDone=0, oResult=0, counter=0, and all operand registers=0.
REQ-025 A reset asserted mid-operation SHALL abort it; no oDone SHALL follow after release.
REQ-026 The first start SHALL be accepted on the first rising edge after iRST_N deasserts.

Configuration
REQ-027 The macro DIV_FAST_EN SHALL select the divide-by-zero and overflow path.
REQ-028 When DIV_FAST_EN is defined, the REQ-020/021 cases SHALL go IDLE->DONE, with oDone high in cycle 2.
REQ-029 When DIV_FAST_EN is undefined, those cases SHALL take the full 34-cycle path and still produce the REQ-020/021 results.

Structure
REQ-030 OPDIV, OPDIVU, OPREM, OPREMU, OPNULL and ZERO SHALL come from the shared parameter package.
REQ-031 The state enum SHALL be added to the shared parameter package.
REQ-032 One combinational sub-module, div_step, SHALL implement a single iteration: inputs partial remainder, divisor and next dividend bit; outputs new remainder and quotient bit.

Verification
REQ-033 OPDIV, iA=-7, iB=2 -> oResult=0xFFFFFFFD (-3), oDone in cycle 34, oBusy high for cycles 1-34.
REQ-034 OPREMU, iA=0xFFFFFFFF, iB=10 -> oResult=5; OPREM, iA=-7, iB=2 -> oResult=0xFFFFFFFF (-1).
REQ-035 OPDIVU, iB=0 -> 0xFFFFFFFF; OPREM, iA=0x1234, iB=0 -> 0x1234; check oDone cycle 2 with DIV_FAST_EN and cycle 34 without.
REQ-036 OPDIV, 0x80000000 / 0xFFFFFFFF -> 0x80000000; OPREM on the same operands -> 0.
REQ-037 Pulse iStart at cycle 10 of an operation with different operands -> ignored, first result unchanged; a start in the cycle after DONE -> accepted.
REQ-038 Drive iRST_N low at cycle 15 of OPDIV 100/7 -> outputs 0, no oDone after release; next OPDIV 100/7 -> 14.

Source files
------------

// File: rtl/divider_unit_pkg.sv
// Shared parameters for the divider: operation codes, result constants,
// the controller state encoding and small opcode decode helpers.
package divider_unit_pkg;

  localparam logic [4:0] OPNULL = 5'd0;
  localparam logic [4:0] OPDIV  = 5'd1;
  localparam logic [4:0] OPDIVU = 5'd2;
  localparam logic [4:0] OPREM  = 5'd3;
  localparam logic [4:0] OPREMU = 5'd4;

  localparam logic [31:0] ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // True for the four opcodes the divider understands.
  function automatic logic op_valid(input logic [4:0] op);
    return (op == OPDIV) || (op == OPDIVU) || (op == OPREM) || (op == OPREMU);
  endfunction

  // True when operands are two's-complement signed.
  function automatic logic op_signed(input logic [4:0] op);
    return (op == OPDIV) || (op == OPREM);
  endfunction

  // True when the remainder, not the quotient, is returned.
  function automatic logic op_rem(input logic [4:0] op);
    return (op == OPREM) || (op == OPREMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into
// the partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             quotient_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction; a clear top bit of diff means the divisor fitted.
  always_comb begin
    shifted      = {rem_in, dividend_bit};
    diff         = shifted - {1'b0, divisor};
    quotient_bit = ~diff[WIDTH];
    rem_out      = quotient_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_unit.sv
// Iterative 32-bit signed/unsigned divider (quotient or remainder).
// Operands are converted to magnitudes on start, 32 restoring iterations run
// one per cycle, then signs and the divide-by-zero / overflow results are
// applied. Invalid opcodes return ZERO through a short path.
// Build option: define DIV_FAST_EN to send divide-by-zero and signed
// overflow through the same short path instead of the full iteration.
module divider_unit
  import divider_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iStart,
  input  logic [4:0]       iControl,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult
);

`ifdef DIV_FAST_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, next_state;
  logic [4:0]       cnt_q;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             div0_q;
  logic             ovf_q;
  logic [WIDTH-1:0] result_q;

  logic             start_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             start_div0;
  logic             start_ovf;
  logic             start_fast;

  logic [WIDTH-1:0] step_rem;
  logic             step_quo;
  logic [WIDTH-1:0] quo_signed;
  logic [WIDTH-1:0] rem_signed;
  logic [WIDTH-1:0] sign_result;

  // Decode the incoming request; magnitudes stay in WIDTH bits so that
  // -2^31 maps to the unsigned value 2^31 without losing a bit.
  always_comb begin
    start_signed = op_signed(iControl);
    a_neg        = start_signed & iA[WIDTH-1];
    b_neg        = start_signed & iB[WIDTH-1];
    a_mag        = a_neg ? (~iA + 1'b1) : iA;
    b_mag        = b_neg ? (~iB + 1'b1) : iB;
    start_div0   = (iB == '0);
    start_ovf    = start_signed && (iA == INT_MIN) && (iB == '1);
    start_fast   = !op_valid(iControl) || (FAST_EN && (start_div0 || start_ovf));
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (rem_q),
    .divisor      (dsr_q),
    .dividend_bit (dvd_q[WIDTH-1]),
    .rem_out      (step_rem),
    .quotient_bit (step_quo)
  );

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // values from before the edge; blocking here would create ordering races.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= next_state;
  end

  // Next-state logic. Short-path requests skip CALC and pass through SIGN
  // so the special result is formed from the latched operands.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      IDLE: if (iStart) next_state = start_fast ? SIGN : CALC;
      CALC: if (cnt_q == 5'd31) next_state = SIGN;
      SIGN: next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Apply signs and the divide-by-zero / overflow results.
  always_comb begin
    quo_signed = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
    rem_signed = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    if (!op_valid(op_q))  sign_result = ZERO;
    else if (div0_q)      sign_result = op_rem(op_q) ? a_q : '1;
    else if (ovf_q)       sign_result = op_rem(op_q) ? ZERO : INT_MIN;
    else                  sign_result = op_rem(op_q) ? rem_signed : quo_signed;
  end

  // Datapath: latch operands on start, iterate in CALC (the dividend
  // register fills with quotient bits), capture the result in SIGN.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (iStart) begin
            cnt_q     <= '0;
            op_q      <= iControl;
            a_q       <= iA;
            dvd_q     <= a_mag;
            dsr_q     <= b_mag;
            rem_q     <= '0;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            div0_q    <= start_div0;
            ovf_q     <= start_ovf;
          end
        end
        CALC: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[WIDTH-2:0], step_quo};
          cnt_q <= cnt_q + 5'd1;
        end
        SIGN: result_q <= sign_result;
        default: ;
      endcase
    end
  end

  assign oBusy   = (state_q != IDLE);
  assign oDone   = (state_q == DONE);
  assign oResult = result_q;

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: stimulus pushes the hand-computed
// result and expected oDone cycle; a monitor pops and compares on oDone.
module tb_divider_unit;
  import divider_unit_pkg::*;

  localparam int NORM_CYC = 34;
`ifdef DIV_FAST_EN
  localparam int FAST_CYC = 2;
`else
  localparam int FAST_CYC = 34;
`endif

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iStart = 1'b0;
  logic [4:0]  iControl = '0;
  logic [31:0] iA = '0;
  logic [31:0] iB = '0;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oResult;

  divider_unit #(.WIDTH(32)) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iStart   (iStart),
    .iControl (iControl),
    .iA       (iA),
    .iB       (iB),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oResult  (oResult)
  );

  always #5 iCLK = ~iCLK;

  // Rising-edge counter used to measure latency.
  int edges = 0;
  always @(posedge iCLK) edges <= edges + 1;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          start;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every oDone pulse must match the oldest pending expectation.
  always @(negedge iCLK) begin : monitor
    exp_t e;
    if (oDone) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got oDone=1 at edge %0d expected no pending operation", edges);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, oResult, e.res);
        check({e.name, "_cycle"}, 32'(edges - e.start + 1), 32'(e.cyc));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge of cycle 1.
  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int s);
    iControl = op;
    iA       = a;
    iB       = b;
    iStart   = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    s      = edges;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && (sb.size() != 0 || oBusy); i++) @(negedge iCLK);
    check({name, "_drain"}, 32'(sb.size()), 32'd0);
    @(negedge iCLK);
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int cyc);
    int s;
    start_op(op, a, b, s);
    sb.push_back('{name, res, s, cyc});
    drain(name);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion expected finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int s;
    int n;

    // Reset state.
    repeat (3) @(negedge iCLK);
    check("reset_busy", 32'(oBusy), 32'd0);
    check("reset_done", 32'(oDone), 32'd0);
    check("reset_result", oResult, 32'd0);

    // First start on the first edge after release; busy for cycles 1..34.
    iRST_N = 1'b1;
    start_op(OPDIV, 32'hFFFF_FFF9, 32'd2, s);
    sb.push_back('{"div_m7_2", 32'hFFFF_FFFD, s, NORM_CYC});
    n = 0;
    while (oBusy && n < 100) begin
      n++;
      @(negedge iCLK);
    end
    check("div_m7_2_busy_cycles", 32'(n), 32'd34);
    drain("div_m7_2");

    // Main function.
    run_op("divu_100_7",  OPDIVU, 32'd100,       32'd7,         32'd14,        NORM_CYC);
    run_op("remu_max_10", OPREMU, 32'hFFFF_FFFF, 32'd10,        32'd5,         NORM_CYC);
    run_op("rem_m7_2",    OPREM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, NORM_CYC);
    run_op("div_min_2",   OPDIV,  32'h8000_0000, 32'd2,         32'hC000_0000, NORM_CYC);
    run_op("div_100_m7",  OPDIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, NORM_CYC);
    run_op("rem_m100_7",  OPREM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, NORM_CYC);
    run_op("divu_min_3",  OPDIVU, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA, NORM_CYC);

    // Divide by zero and signed overflow.
    run_op("divu_by0",    OPDIVU, 32'h0000_0055, 32'd0,         32'hFFFF_FFFF, FAST_CYC);
    run_op("rem_by0",     OPREM,  32'h0000_1234, 32'd0,         32'h0000_1234, FAST_CYC);
    run_op("div_neg_by0", OPDIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, FAST_CYC);
    run_op("remu_by0",    OPREMU, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, FAST_CYC);
    run_op("div_ovf",     OPDIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FAST_CYC);
    run_op("rem_ovf",     OPREM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         FAST_CYC);

    // Unknown opcodes take the short path to ZERO.
    run_op("bad_op",      5'd31,  32'd5,         32'd3,         32'd0,         2);
    run_op("null_op",     OPNULL, 32'd9,         32'd3,         32'd0,         2);

    // Start while busy is ignored; start held through DONE lands in IDLE.
    start_op(OPDIV, 32'd1000, 32'd10, s);
    sb.push_back('{"div_1000_10", 32'd100, s, NORM_CYC});
    repeat (9) @(negedge iCLK);
    iControl = OPDIVU;
    iA       = 32'd7;
    iB       = 32'd7;
    iStart   = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    repeat (23) @(negedge iCLK);
    iControl = OPDIVU;
    iA       = 32'd50;
    iB       = 32'd5;
    iStart   = 1'b1;
    @(negedge iCLK);
    @(negedge iCLK);
    iStart = 1'b0;
    s      = edges;
    sb.push_back('{"start_after_done", 32'd10, s, NORM_CYC});
    drain("start_after_done");

    // Reset in cycle 15 of an operation aborts it.
    run_op("divu_100_7b", OPDIVU, 32'd100, 32'd7, 32'd14, NORM_CYC);
    start_op(OPDIV, 32'd100, 32'd7, s);
    repeat (14) @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    check("abort_busy", 32'(oBusy), 32'd0);
    check("abort_done", 32'(oDone), 32'd0);
    check("abort_result", oResult, 32'd0);
    @(negedge iCLK);
    @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (40) @(negedge iCLK);
    check("after_abort_busy", 32'(oBusy), 32'd0);
    run_op("div_100_7", OPDIV, 32'd100, 32'd7, 32'd14, NORM_CYC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
